// File: rtl/alu_pkg.sv
// Shared constants for the ALU operand path: op codes, widths, skid states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package alu_pkg;

  localparam int ALU_WIDTH = 32;
  localparam int ALU_NREGS = 32;
  localparam int ALU_AW    = $clog2(ALU_NREGS);
  localparam int ALU_CW    = 3;

  // ALU operation codes carried on the control field.
  typedef enum logic [ALU_CW-1:0] {
    ALU_NOP = 3'd0,
    ALU_ADD = 3'd1,
    ALU_SUB = 3'd2,
    ALU_AND = 3'd3,
    ALU_OR  = 3'd4,
    ALU_XOR = 3'd5,
    ALU_SLT = 3'd6,
    ALU_SLL = 3'd7
  } alu_op_e;

  // Skid buffer occupancy: nothing held, main entry only, main plus skid.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

endpackage

// File: rtl/regfile_2r1w.sv
// Register file, 2 combinational read ports, 1 synchronous write port, R0 = 0.
// Latency: reads are combinational; writes land at the next clk edge.
// Backpressure: none; every write with we=1 is taken, reset clears all entries.
module regfile_2r1w #(
  parameter int WIDTH = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    raddr0,
  output logic [WIDTH-1:0] rdata0,
  input  logic [AW-1:0]    raddr1,
  output logic [WIDTH-1:0] rdata1,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata
);

  logic [WIDTH-1:0] mem_q [NREGS];

  // Storage: synchronous clear wins over writes; R0 is never written.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read ports: R0 is forced to zero regardless of storage contents.
  always_comb begin
    rdata0 = '0;
    rdata1 = '0;
    if (raddr0 != '0) rdata0 = mem_q[raddr0];
    if (raddr1 != '0) rdata1 = mem_q[raddr1];
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Operand fetch for the ALU: register read with write bypass into a 2-entry skid buffer.
// Latency: an op accepted at cycle N is presented with out_valid=1 at cycle N+1.
// Backpressure: in_ready is registered and drops only when main and skid are both full.
module alu_operand_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int NREGS = ALU_NREGS,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [AW-1:0]    in_rs0,
  input  logic [AW-1:0]    in_rs1,
  input  logic [AW-1:0]    in_rd,
  input  logic [2:0]       in_control,
  input  logic             wb_en,
  input  logic [AW-1:0]    wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] operand0,
  output logic [WIDTH-1:0] operand1,
  output logic [2:0]       control,
  output logic [AW-1:0]    out_rd
);

  logic [1:0]       state_q, state_d;
  logic             in_ready_q, in_ready_d;

  // Main entry drives the outputs; skid holds the second op under backpressure.
  logic [WIDTH-1:0] main_op0_q, main_op0_d;
  logic [WIDTH-1:0] main_op1_q, main_op1_d;
  logic [2:0]       main_ctl_q, main_ctl_d;
  logic [AW-1:0]    main_rd_q,  main_rd_d;
  logic [WIDTH-1:0] skid_op0_q, skid_op0_d;
  logic [WIDTH-1:0] skid_op1_q, skid_op1_d;
  logic [2:0]       skid_ctl_q, skid_ctl_d;
  logic [AW-1:0]    skid_rd_q,  skid_rd_d;

  logic [WIDTH-1:0] rf_rdata0, rf_rdata1;
  logic [WIDTH-1:0] fetch_op0, fetch_op1;
  logic             accept, issue;

  regfile_2r1w #(
    .WIDTH (WIDTH),
    .NREGS (NREGS),
    .AW    (AW)
  ) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .raddr0 (in_rs0),
    .rdata0 (rf_rdata0),
    .raddr1 (in_rs1),
    .rdata1 (rf_rdata1),
    .we     (wb_en),
    .waddr  (wb_addr),
    .wdata  (wb_data)
  );

  assign accept = in_valid && in_ready_q;
  assign issue  = out_valid && out_ready;

  // Operand select: a same-cycle writeback to a nonzero source overrides storage.
  always_comb begin
    fetch_op0 = rf_rdata0;
    fetch_op1 = rf_rdata1;
    if (wb_en && (wb_addr == in_rs0) && (in_rs0 != '0)) fetch_op0 = wb_data;
    if (wb_en && (wb_addr == in_rs1) && (in_rs1 != '0)) fetch_op1 = wb_data;
  end

  // Skid control: decide occupancy and which entry loads what, keeping FIFO order.
  always_comb begin
    state_d    = state_q;
    main_op0_d = main_op0_q;
    main_op1_d = main_op1_q;
    main_ctl_d = main_ctl_q;
    main_rd_d  = main_rd_q;
    skid_op0_d = skid_op0_q;
    skid_op1_d = skid_op1_q;
    skid_ctl_d = skid_ctl_q;
    skid_rd_d  = skid_rd_q;

    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_op0_d = fetch_op0;
          main_op1_d = fetch_op1;
          main_ctl_d = in_control;
          main_rd_d  = in_rd;
          state_d    = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && !issue) begin
          // Main must hold still for the stalled consumer; park the new op.
          skid_op0_d = fetch_op0;
          skid_op1_d = fetch_op1;
          skid_ctl_d = in_control;
          skid_rd_d  = in_rd;
          state_d    = ST_TWO;
        end else if (accept && issue) begin
          // Back-to-back streaming: replace main in the same cycle it leaves.
          main_op0_d = fetch_op0;
          main_op1_d = fetch_op1;
          main_ctl_d = in_control;
          main_rd_d  = in_rd;
        end else if (issue) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        // in_ready is low here, so only the older skid entry can advance.
        if (issue) begin
          main_op0_d = skid_op0_q;
          main_op1_d = skid_op1_q;
          main_ctl_d = skid_ctl_q;
          main_rd_d  = skid_rd_q;
          state_d    = ST_ONE;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    in_ready_d = (state_d != ST_TWO);
  end

  // State and payload registers; reset discards any buffered ops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
      main_op0_q <= '0;
      main_op1_q <= '0;
      main_ctl_q <= ALU_NOP;
      main_rd_q  <= '0;
      skid_op0_q <= '0;
      skid_op1_q <= '0;
      skid_ctl_q <= ALU_NOP;
      skid_rd_q  <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      main_op0_q <= main_op0_d;
      main_op1_q <= main_op1_d;
      main_ctl_q <= main_ctl_d;
      main_rd_q  <= main_rd_d;
      skid_op0_q <= skid_op0_d;
      skid_op1_q <= skid_op1_d;
      skid_ctl_q <= skid_ctl_d;
      skid_rd_q  <= skid_rd_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign operand0  = main_op0_q;
  assign operand1  = main_op1_q;
  assign control   = main_ctl_q;
  assign out_rd    = main_rd_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: queue/array reference model plus directed literal checks.
// Latency: model expects issue-side data one cycle after acceptance.
// Backpressure: out_ready is driven directly by the directed sequence.
module tb_alu_operand_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs0, in_rs1, in_rd;
  logic [2:0]  in_control;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] operand0, operand1;
  logic [2:0]  control;
  logic [4:0]  out_rd;

  alu_operand_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rs0     (in_rs0),
    .in_rs1     (in_rs1),
    .in_rd      (in_rd),
    .in_control (in_control),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .operand0   (operand0),
    .operand1   (operand1),
    .control    (control),
    .out_rd     (out_rd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cmp_cnt = 0;
  int err_cnt = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: architectural registers plus an ordered queue of pending bundles.
  typedef struct {
    logic [31:0] o0;
    logic [31:0] o1;
    logic [2:0]  c;
    logic [4:0]  rd;
  } exp_t;

  exp_t        mq[$];
  logic [31:0] mregs [32];
  bit          m_iss, m_acc;
  exp_t        m_e;

  function automatic logic [31:0] model_read(input logic [4:0] rs);
    if (rs == 5'd0) return 32'd0;
    if (wb_en && wb_addr == rs) return wb_data;
    return mregs[rs];
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    end else begin
      m_iss = (mq.size() != 0) && out_ready;
      m_acc = in_valid && (mq.size() < 2);
      if (m_acc) begin
        m_e.o0 = model_read(in_rs0);
        m_e.o1 = model_read(in_rs1);
        m_e.c  = in_control;
        m_e.rd = in_rd;
      end
      if (m_iss) void'(mq.pop_front());
      if (m_acc) mq.push_back(m_e);
      if (wb_en && wb_addr != 5'd0) mregs[wb_addr] = wb_data;
    end
  end

  // Per-cycle compare of DUT outputs against the model.
  logic exp_vld, exp_rdy;
  always @(negedge clk) begin
    if (chk_en) begin
      exp_vld = (mq.size() != 0);
      exp_rdy = (mq.size() < 2);
      chk("m_out_valid", {31'd0, out_valid}, {31'd0, exp_vld});
      chk("m_in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      if (exp_vld) begin
        chk("m_operand0", operand0, mq[0].o0);
        chk("m_operand1", operand1, mq[0].o1);
        chk("m_control", {29'd0, control}, {29'd0, mq[0].c});
        chk("m_out_rd", {27'd0, out_rd}, {27'd0, mq[0].rd});
      end
    end
  end

  task automatic set_op(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                        input logic [4:0] rd, input logic [2:0] ctl);
    in_valid   = v;
    in_rs0     = rs0;
    in_rs1     = rs1;
    in_rd      = rd;
    in_control = ctl;
  endtask

  task automatic set_wb(input logic en, input logic [4:0] a, input logic [31:0] d);
    wb_en   = en;
    wb_addr = a;
    wb_data = d;
  endtask

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b0;
    set_op(1'b0, 5'd0, 5'd0, 5'd0, 3'd0);
    set_wb(1'b0, 5'd0, 32'd0);

    // Reset then idle.
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_operand0", operand0, 32'd0);
    chk("rst_operand1", operand1, 32'd0);
    chk_en = 1'b1;
    rst_n  = 1'b1;
    out_ready = 1'b1;
    set_op(1'b1, 5'd5, 5'd0, 5'd1, 3'd1);
    @(negedge clk);
    chk("r5_valid", {31'd0, out_valid}, 32'd1);
    chk("r5_operand0", operand0, 32'd0);
    set_op(1'b0, 5'd0, 5'd0, 5'd0, 3'd0);

    // Write R3, R4 then read them back.
    set_wb(1'b1, 5'd3, 32'd500);
    @(negedge clk);
    set_wb(1'b1, 5'd4, 32'hFFFF_FFE6);
    @(negedge clk);
    set_wb(1'b0, 5'd0, 32'd0);
    set_op(1'b1, 5'd3, 5'd4, 5'd7, 3'd2);
    @(negedge clk);
    chk("wr_valid", {31'd0, out_valid}, 32'd1);
    chk("wr_operand0", operand0, 32'd500);
    chk("wr_operand1", operand1, 32'hFFFF_FFE6);
    chk("wr_control", {29'd0, control}, 32'd2);
    chk("wr_out_rd", {27'd0, out_rd}, 32'd7);

    // Same-cycle bypass on rs0 while rs1 is R0.
    set_wb(1'b1, 5'd9, 32'h8000_0000);
    set_op(1'b1, 5'd9, 5'd0, 5'd2, 3'd1);
    @(negedge clk);
    chk("byp_operand0", operand0, 32'h8000_0000);
    chk("byp_operand1", operand1, 32'd0);
    // Write to R0 must not stick.
    set_wb(1'b1, 5'd0, 32'hFFFF_FFFF);
    set_op(1'b0, 5'd0, 5'd0, 5'd0, 3'd0);
    @(negedge clk);
    set_wb(1'b0, 5'd0, 32'd0);
    set_op(1'b1, 5'd0, 5'd9, 5'd3, 3'd3);
    @(negedge clk);
    chk("r0_operand0", operand0, 32'd0);
    chk("r9_operand1", operand1, 32'h8000_0000);
    // Bypass on rs1 with an older stored value on rs0.
    set_wb(1'b1, 5'd9, 32'h0000_1234);
    set_op(1'b1, 5'd3, 5'd9, 5'd4, 3'd5);
    @(negedge clk);
    chk("byp1_operand0", operand0, 32'd500);
    chk("byp1_operand1", operand1, 32'h0000_1234);
    set_wb(1'b0, 5'd0, 32'd0);
    set_op(1'b0, 5'd0, 5'd0, 5'd0, 3'd0);
    repeat (2) @(negedge clk);

    // Backpressure: A and B accepted, C held until the consumer drains.
    out_ready = 1'b0;
    set_op(1'b1, 5'd3, 5'd4, 5'd10, 3'd1);
    @(negedge clk);
    set_op(1'b1, 5'd4, 5'd3, 5'd11, 3'd2);
    @(negedge clk);
    set_op(1'b1, 5'd9, 5'd3, 5'd12, 3'd4);
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_hold_rd", {27'd0, out_rd}, 32'd10);
      chk("bp_hold_op0", operand0, 32'd500);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_second_rd", {27'd0, out_rd}, 32'd11);
    chk("bp_ready_back", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    chk("bp_third_rd", {27'd0, out_rd}, 32'd12);
    set_op(1'b0, 5'd0, 5'd0, 5'd0, 3'd0);
    @(negedge clk);
    chk("bp_drained", {31'd0, out_valid}, 32'd0);

    // Streaming: one op per cycle, one-cycle latency.
    for (int i = 0; i < 10; i++) begin
      set_op(1'b1, 5'(i % 5), 5'(9 - i % 3), 5'(16 + i), 3'(i % 8));
      @(negedge clk);
      chk("st_rd", {27'd0, out_rd}, 32'(16 + i));
      chk("st_in_ready", {31'd0, in_ready}, 32'd1);
    end
    set_op(1'b0, 5'd0, 5'd0, 5'd0, 3'd0);
    repeat (2) @(negedge clk);

    // Reset while both entries are full; reset also beats a writeback.
    out_ready = 1'b0;
    set_op(1'b1, 5'd3, 5'd4, 5'd1, 3'd1);
    @(negedge clk);
    set_op(1'b1, 5'd4, 5'd3, 5'd2, 3'd1);
    @(negedge clk);
    chk("two_in_ready", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    set_wb(1'b1, 5'd5, 32'h0000_DEAD);
    @(negedge clk);
    chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mrst_operand0", operand0, 32'd0);
    chk("mrst_out_rd", {27'd0, out_rd}, 32'd0);
    rst_n = 1'b1;
    set_wb(1'b0, 5'd0, 32'd0);
    out_ready = 1'b1;
    set_op(1'b1, 5'd5, 5'd3, 5'd6, 3'd7);
    @(negedge clk);
    chk("mrst_r5", operand0, 32'd0);
    chk("mrst_r3", operand1, 32'd0);
    set_op(1'b1, 5'd4, 5'd9, 5'd8, 3'd6);
    @(negedge clk);
    chk("mrst_r4", operand0, 32'd0);
    chk("mrst_r9", operand1, 32'd0);
    set_op(1'b0, 5'd0, 5'd0, 5'd0, 3'd0);
    repeat (3) @(negedge clk);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
